// File: rtl/input_pkg.sv
// Shared definitions for the front-panel input conditioning blocks.
package input_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_RISING  = 2'd1,
    S_HIGH    = 2'd2,
    S_FALLING = 2'd3
  } debounce_state_t;

  // Consecutive agreeing samples required before a new level is accepted.
  localparam int unsigned DEFAULT_STABLE_SAMPLES = 4;
  localparam int unsigned DEFAULT_SYNC_DEPTH     = 2;

endpackage : input_pkg

// File: rtl/button_debouncer_if.sv
// Sample strobe, raw pin and conditioned outputs of one panel button.
interface button_debouncer_if;
  logic tick;
  logic raw;
  logic out;
  logic pressed;
  logic released;

  modport master (output tick, raw, input out, pressed, released);
  modport slave  (input tick, raw, output out, pressed, released);
endinterface : button_debouncer_if

// File: rtl/button_debouncer_synchronizer.sv
// Multi-flop synchronizer for asynchronous panel inputs, reset to 0.
module synchronizer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  if (DEPTH < 2) begin : g_bad_depth
    $error("synchronizer: DEPTH must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule : synchronizer

// File: rtl/button_debouncer.sv
// Debounces one raw button into a clean level plus press/release pulses,
// accepting a change only after STABLE_SAMPLES consecutive agreeing ticks.
module button_debouncer
  import input_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
  input  logic                clk,
  input  logic                rst,
  button_debouncer_if.slave   bus
);

  localparam longint unsigned CNT_MAX = (64'(1) << N) - 64'(1);

  if (STABLE_SAMPLES < 2 || 64'(STABLE_SAMPLES) > CNT_MAX) begin : g_bad_param
    $error("button_debouncer: STABLE_SAMPLES must lie in 2..2**N-1");
  end

  debounce_state_t state_q, state_d;
  logic [N-1:0]    count_q, count_d;
  logic            out_q, out_d;
  logic            pressed_q, pressed_d;
  logic            released_q, released_d;
  logic            sync;
  logic [N-1:0]    count_inc;

  synchronizer #(.DEPTH(DEFAULT_SYNC_DEPTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.raw),
    .q_o (sync)
  );

  assign count_inc = count_q + N'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LOW;
      count_q    <= '0;
      out_q      <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      out_q      <= out_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  // Candidate states abort on any tick that samples the old level.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    if (bus.tick) begin
      unique case (state_q)
        S_LOW: begin
          if (sync) begin
            state_d = S_RISING;
            count_d = N'(1);
          end
        end
        S_RISING: begin
          if (!sync) begin
            state_d = S_LOW;
            count_d = '0;
          end else if (count_inc == N'(STABLE_SAMPLES)) begin
            state_d   = S_HIGH;
            count_d   = '0;
            pressed_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            state_d = S_FALLING;
            count_d = N'(1);
          end
        end
        S_FALLING: begin
          if (sync) begin
            state_d = S_HIGH;
            count_d = '0;
          end else if (count_inc == N'(STABLE_SAMPLES)) begin
            state_d    = S_LOW;
            count_d    = '0;
            released_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
        default: begin
          state_d = S_LOW;
          count_d = '0;
        end
      endcase
    end
    out_d = (state_d == S_HIGH) || (state_d == S_FALLING);
  end

  assign bus.out      = out_q;
  assign bus.pressed  = pressed_q;
  assign bus.released = released_q;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (STABLE_SAMPLES=4, N=8).
module tb_button_debouncer;
  import input_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   pcnt  = 0;
  int   rcnt  = 0;
  int   viol  = 0;
  logic prev_p = 1'b0;
  logic prev_r = 1'b0;

  button_debouncer_if bus_if ();

  button_debouncer #(.N(8), .STABLE_SAMPLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample just after the edge and tally pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus_if.pressed === 1'b1) pcnt++;
    if (bus_if.released === 1'b1) rcnt++;
    if ((bus_if.pressed && bus_if.released) || (bus_if.pressed && prev_p) ||
        (bus_if.released && prev_r)) viol++;
    prev_p = bus_if.pressed;
    prev_r = bus_if.released;
  endtask

  // Nine idle cycles then one tick cycle, raw held at r throughout.
  task automatic do_tick(input logic r);
    bus_if.raw = r;
    bus_if.tick = 1'b0;
    repeat (9) step();
    bus_if.tick = 1'b1;
    step();
    bus_if.tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.raw = 1'b1;
    bus_if.tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus_if.out !== 1'b0) begin bad++; $display("FAIL reset_out cyc=%0d got=%b want=0", i, bus_if.out); end
      total++; if (bus_if.pressed !== 1'b0) begin bad++; $display("FAIL reset_pressed cyc=%0d got=%b want=0", i, bus_if.pressed); end
      total++; if (bus_if.released !== 1'b0) begin bad++; $display("FAIL reset_released cyc=%0d got=%b want=0", i, bus_if.released); end
    end
    bus_if.tick = 1'b0;
    rst = 1'b1;
    pcnt = 0;
    repeat (3) do_tick(1'b1);
    total++; if (pcnt !== 0) begin bad++; $display("FAIL reset_early_press got=%0d want=0", pcnt); end
    total++; if (bus_if.out !== 1'b0) begin bad++; $display("FAIL reset_early_out got=%b want=0", bus_if.out); end
    do_tick(1'b1);
    total++; if (bus_if.pressed !== 1'b1) begin bad++; $display("FAIL reset_press_pulse got=%b want=1", bus_if.pressed); end
    total++; if (pcnt !== 1) begin bad++; $display("FAIL reset_press_count got=%0d want=1", pcnt); end
    total++; if (bus_if.out !== 1'b1) begin bad++; $display("FAIL reset_out_high got=%b want=1", bus_if.out); end
  endtask

  task automatic test_release();
    pcnt = 0; rcnt = 0;
    repeat (3) do_tick(1'b0);
    total++; if (rcnt !== 0) begin bad++; $display("FAIL release_early got=%0d want=0", rcnt); end
    total++; if (bus_if.out !== 1'b1) begin bad++; $display("FAIL release_hold_out got=%b want=1", bus_if.out); end
    do_tick(1'b0);
    total++; if (bus_if.released !== 1'b1) begin bad++; $display("FAIL release_pulse got=%b want=1", bus_if.released); end
    total++; if (bus_if.out !== 1'b0) begin bad++; $display("FAIL release_out got=%b want=0", bus_if.out); end
    step();
    total++; if (bus_if.released !== 1'b0) begin bad++; $display("FAIL release_pulse_end got=%b want=0", bus_if.released); end
    total++; if (rcnt !== 1 || pcnt !== 0) begin bad++; $display("FAIL release_counts got=r%0d/p%0d want=r1/p0", rcnt, pcnt); end
  endtask

  task automatic test_clean_press();
    pcnt = 0; rcnt = 0;
    bus_if.tick = 1'b1;
    bus_if.raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++; if (bus_if.out !== 1'b0) begin bad++; $display("FAIL clean_latency_out cyc=%0d got=%b want=0", i, bus_if.out); end
    end
    step();
    total++; if (bus_if.out !== 1'b1) begin bad++; $display("FAIL clean_out_rise got=%b want=1", bus_if.out); end
    total++; if (bus_if.pressed !== 1'b1) begin bad++; $display("FAIL clean_pressed got=%b want=1", bus_if.pressed); end
    step();
    total++; if (bus_if.pressed !== 1'b0) begin bad++; $display("FAIL clean_pressed_end got=%b want=0", bus_if.pressed); end
    total++; if (bus_if.out !== 1'b1) begin bad++; $display("FAIL clean_out_hold got=%b want=1", bus_if.out); end
    bus_if.raw = 1'b0;
    repeat (6) step();
    bus_if.tick = 1'b0;
    total++; if (bus_if.out !== 1'b0 || rcnt !== 1) begin bad++; $display("FAIL clean_release got=out%b/r%0d want=out0/r1", bus_if.out, rcnt); end
  endtask

  task automatic test_bounce();
    pcnt = 0; rcnt = 0;
    repeat (3) do_tick(1'b1);
    do_tick(1'b0);
    total++; if (pcnt !== 0 || bus_if.out !== 1'b0) begin bad++; $display("FAIL bounce_reject got=p%0d/out%b want=p0/out0", pcnt, bus_if.out); end
    repeat (3) do_tick(1'b1);
    total++; if (pcnt !== 0) begin bad++; $display("FAIL bounce_restart got=%0d want=0", pcnt); end
    do_tick(1'b1);
    total++; if (pcnt !== 1 || bus_if.out !== 1'b1) begin bad++; $display("FAIL bounce_accept got=p%0d/out%b want=p1/out1", pcnt, bus_if.out); end
  endtask

  task automatic test_glitch();
    pcnt = 0; rcnt = 0;
    do_tick(1'b1);
    bus_if.raw = 1'b1; repeat (2) step();
    bus_if.raw = 1'b0; repeat (3) step();
    bus_if.raw = 1'b1; repeat (4) step();
    bus_if.tick = 1'b1; step();
    bus_if.tick = 1'b0;
    total++; if (pcnt !== 0 || rcnt !== 0) begin bad++; $display("FAIL glitch_pulses got=p%0d/r%0d want=p0/r0", pcnt, rcnt); end
    total++; if (bus_if.out !== 1'b1 || dut.state_q !== S_HIGH) begin bad++; $display("FAIL glitch_state got=out%b/st%0d want=out1/st2", bus_if.out, dut.state_q); end
    repeat (4) do_tick(1'b0);
    total++; if (rcnt !== 1 || pcnt !== 0) begin bad++; $display("FAIL glitch_release got=r%0d/p%0d want=r1/p0", rcnt, pcnt); end
  endtask

  task automatic test_reset_mid();
    pcnt = 0; rcnt = 0;
    repeat (3) do_tick(1'b1);
    total++; if (dut.state_q !== S_RISING || dut.count_q !== 8'd3) begin bad++; $display("FAIL mid_candidate got=st%0d/cnt%0d want=st1/cnt3", dut.state_q, dut.count_q); end
    rst = 1'b0; step(); rst = 1'b1;
    total++; if (dut.state_q !== S_LOW || dut.count_q !== 8'd0) begin bad++; $display("FAIL mid_reset_state got=st%0d/cnt%0d want=st0/cnt0", dut.state_q, dut.count_q); end
    repeat (3) do_tick(1'b1);
    total++; if (pcnt !== 0) begin bad++; $display("FAIL mid_no_early_press got=%0d want=0", pcnt); end
    do_tick(1'b1);
    total++; if (pcnt !== 1 || bus_if.pressed !== 1'b1) begin bad++; $display("FAIL mid_press got=p%0d/pulse%b want=p1/pulse1", pcnt, bus_if.pressed); end
    // Reset while held high: outputs clear, no release, and the held button is re-detected.
    pcnt = 0;
    rst = 1'b0; step(); rst = 1'b1;
    total++; if (bus_if.out !== 1'b0 || rcnt !== 0) begin bad++; $display("FAIL high_reset got=out%b/r%0d want=out0/r0", bus_if.out, rcnt); end
    repeat (4) do_tick(1'b1);
    total++; if (pcnt !== 1 || rcnt !== 0 || bus_if.out !== 1'b1) begin bad++; $display("FAIL high_redetect got=p%0d/r%0d/out%b want=p1/r0/out1", pcnt, rcnt, bus_if.out); end
  endtask

  initial begin
    rst = 1'b0;
    bus_if.tick = 1'b0;
    bus_if.raw = 1'b0;
    test_reset();
    test_release();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    total++; if (viol !== 0) begin bad++; $display("FAIL pulse_rules got=%0d want=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
# button_debouncer

Debounces one raw mechanical button input for the etch-a-sketch front panel. It consumes the one-cycle sample strobe produced by the upstream tick/pulse generator stage and emits three outputs:
- a clean level;
- a one-cycle `pressed` pulse;
- a one-cycle `released` pulse.

The cursor and colour logic use only these outputs and never the raw pin. The block contains a 2-flop synchronizer, a 4-state debounce FSM and a stability counter.

## Interface
Parameters:
- `N`, default 8: width of the stability counter.
- `STABLE_SAMPLES`, default 4: number of consecutive ticks that must sample the new level before the change is accepted. Legal range is 2..2**N-1.

Ports:
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-low reset. Sampled on the `clk` rising edge; `rst==0` resets the block.
- `tick` input, 1 bit: one-cycle sample strobe from the pulse generator. Tied high means the block samples every cycle.
- `raw` input, 1 bit: asynchronous button pin, active-high. Bounces.
- `out` output, 1 bit: debounced, registered level.
- `pressed` output, 1 bit: high for exactly one cycle when `out` goes 0→1.
- `released` output, 1 bit: high for exactly one cycle when `out` goes 1→0.

## Operation
- **Synchronizer:** `raw` passes through 2 flops to give `sync`. Both flops reset to 0.
- **FSM states:**
  - S_LOW: stable 0.
  - S_RISING: candidate 1.
  - S_HIGH: stable 1.
  - S_FALLING: candidate 0.
- **Non-tick cycles (`tick==0`):** state and count hold.
- **S_LOW, tick with `sync==1`:** go to S_RISING with count=1.
- **S_LOW, tick with `sync==0`:** stay in S_LOW.
- **S_RISING, tick with `sync==1`:** count+1.
  - If count+1 == STABLE_SAMPLES: go to S_HIGH, clear count, and assert `pressed` next cycle.
- **S_RISING, tick with `sync==0`:** return to S_LOW with count=0. This is a bounce rejection and produces no pulse.
- **S_HIGH / S_FALLING:** mirror S_LOW / S_RISING with the polarity inverted. Acceptance goes to S_LOW and asserts `released`.
- **Output level:** `out`=1 in S_HIGH and S_FALLING, 0 otherwise.
  - `out` is registered, so it never glitches during candidate states.
- **Counter width:** the counter is N bits and never wraps. The parameter bound guarantees the acceptance compare is hit before overflow.
- **`pressed`/`released`:**
  - Registered.
  - Never both high in the same cycle.
  - Never high for two consecutive cycles.

## Timing
- **Reset values:** `out`=0, `pressed`=0, `released`=0, state S_LOW, count=0, synchronizer flops 0.
- **Input latency:** a `raw` edge at cycle t is visible as `sync` at t+2.
- **Acceptance latency:** `out` and `pressed` (or `released`) change in the cycle after the STABLE_SAMPLES-th consecutive tick that sampled the new level.
  - With `tick` tied high, a clean edge is accepted with latency 2 + STABLE_SAMPLES cycles.
- **Bounce during a candidate state:** any tick that samples the old level aborts the candidate and resets count. Non-tick cycles in between are ignored, even if `sync` toggles.
- **Reset mid-operation:**
  - Outputs clear on the reset edge.
  - No `released` is emitted.
  - A button still held after reset is re-detected from S_LOW, and `pressed` fires again after STABLE_SAMPLES ticks.
- **Tick coinciding with reset:** reset wins.
- **Parameter error:** `STABLE_SAMPLES` < 2 or > 2**N-1 is flagged by an elaboration-time assertion.

## Structure
- **Shared package `input_pkg`:**
  - The `debounce_state_t` enum (S_LOW, S_RISING, S_HIGH, S_FALLING).
  - The default-sample-count constant, which is shared with the other panel inputs.
- **Sub-module `synchronizer`:**
  - Parameterised flop depth, default 2.
  - Same clock and active-low synchronous reset as the parent.
  - Reusable for the other panel switches.
- **Top level:** instantiates `synchronizer` plus the FSM, counter and output registers.

## Test plan
All scenarios use STABLE_SAMPLES=4, N=8, and `tick` every 10 cycles unless noted.
- **Reset:** hold `rst`=0 for 3 cycles with `raw`=1 → `out`, `pressed` and `released` are all 0 throughout. After release, `pressed` pulses once after the 4th tick sampling `sync`=1.
- **Clean press, `tick` tied high:** `raw` 0→1 at cycle 10 → `out` and `pressed` go high at cycle 16. `pressed` is low at cycle 17, and `out` stays 1.
- **Bounce rejection:** `raw` is high for ticks 1–3, then low at tick 4 → `out` stays 0 with no `pressed`. Then 4 consecutive high ticks → exactly one `pressed`.
- **Release:** from S_HIGH, `raw`=0 for 4 ticks → `released` pulses once and `out`=0. `pressed` is never asserted during the release.
- **Glitch between ticks:** `raw` pulses low for 3 cycles between two ticks while held high → no state change and no pulses.
- **Reset mid-candidate:** reset in S_RISING with count=3 → state S_LOW and count 0. The next 3 high ticks produce no `pressed`; the 4th produces it.
